// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM encoding, frame geometry, default timing.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_DATA      = 3'd3,
    S_PARITY    = 3'd4,
    S_STOP      = 3'd5,
    S_ACK       = 3'd6,
    S_WAIT_IDLE = 3'd7
  } ps2_state_t;

  // Host-to-device frame: 8 data + parity + stop + ack = 11 device clock edges.
  localparam int FRAME_EDGES = 11;
  localparam int DATA_BITS   = FRAME_EDGES - 3;

  // Cycles the host holds clock and data both low before releasing clock.
  localparam int REQ_CYCLES = 16;

  localparam int DEF_CLK_HZ         = 50_000_000;
  localparam int DEF_INHIBIT_CYCLES = 6000;
  localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

  // PS/2 uses odd parity over the data byte.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer with a third history flop for falling-edge detect.
module ps2_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic sync_o,
  output logic fall_o
);

  logic [2:0] sh_q;

  // Shift the raw line through; idle PS/2 lines are high, so reset to 1s.
  always_ff @(posedge clk_i) begin
    if (rst_i) sh_q <= 3'b111;
    else       sh_q <= {sh_q[1:0], d_i};
  end

  assign sync_o = sh_q[1];
  assign fall_o = sh_q[2] & ~sh_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter. Outputs are open-drain enables:
// the pad wrapper drives PS2_CLK = ps2_clk_oe ? 1'b0 : 1'bz, same for PS2_DAT.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = DEF_CLK_HZ,
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] cmd_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int CMAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int TW   = $clog2(TIMEOUT_CYCLES) + 1;

  // Timing constants assume a clock fast enough to resolve PS/2 (10-16 kHz).
  if (CLK_HZ < 1_000_000) begin : g_clk_chk
    $error("ps2_host_tx: CLK_HZ too low for PS/2 timing");
  end

  logic clk_s, clk_fall, dat_s;
  logic [1:0] dat_sync_q;

  ps2_sync_edge u_clk_sync (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .d_i    (ps2_clk_in),
    .sync_o (clk_s),
    .fall_o (clk_fall)
  );

  // Data line only needs synchronizing; it is sampled on clock edges.
  always_ff @(posedge CLOCK_50) begin
    if (reset) dat_sync_q <= 2'b11;
    else       dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
  end
  assign dat_s = dat_sync_q[1];

  ps2_state_t    state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic          par_q, par_d;
  logic [2:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic          done_q, done_d, err_q, err_d;

  logic inh_last, req_last, in_frame, tmo_fire;

  assign inh_last = (cnt_q == CW'(INHIBIT_CYCLES - 1));
  assign req_last = (cnt_q == CW'(REQ_CYCLES - 1));
  assign in_frame = (state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP) ||
                    (state_q == S_ACK)  || (state_q == S_WAIT_IDLE);
  // A falling edge restarts the watchdog, so it takes priority over expiry.
  assign tmo_fire = in_frame && !clk_fall && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // State register and datapath registers; reset aborts silently.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      byte_q   <= '0;
      par_q    <= 1'b0;
      bit_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      par_q    <= par_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state, bit index, phase counter and watchdog.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    par_d   = par_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    if (in_frame) tmo_d = clk_fall ? '0 : tmo_q + TW'(1);
    case (state_q)
      S_IDLE: if (send) begin
        byte_d  = cmd_byte;
        par_d   = odd_parity(cmd_byte);
        cnt_d   = '0;
        state_d = S_INHIBIT;
      end
      S_INHIBIT: begin
        cnt_d = cnt_q + CW'(1);
        if (inh_last) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (req_last) begin
          cnt_d   = '0;
          bit_d   = '0;
          tmo_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: if (clk_fall) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'(DATA_BITS - 1)) state_d = S_PARITY;
      end
      S_PARITY:    if (clk_fall) state_d = S_STOP;
      S_STOP:      if (clk_fall) state_d = S_ACK;
      S_ACK:       if (clk_fall) state_d = dat_s ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (clk_s && dat_s) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (tmo_fire) state_d = S_IDLE;
  end

  // Next values of the registered line enables and status pulses.
  always_comb begin
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE:      if (send) begin clk_oe_d = 1'b1; dat_oe_d = 1'b0; end
      S_INHIBIT:   if (inh_last) dat_oe_d = 1'b1;
      S_REQ:       if (req_last) clk_oe_d = 1'b0;
      S_DATA:      if (clk_fall) dat_oe_d = ~byte_q[bit_q];
      S_PARITY:    if (clk_fall) dat_oe_d = ~par_q;
      S_STOP:      if (clk_fall) dat_oe_d = 1'b0;
      S_ACK:       if (clk_fall && dat_s) err_d = 1'b1;
      S_WAIT_IDLE: if (clk_s && dat_s) done_d = 1'b1;
      default:     ;
    endcase
    if (tmo_fire && !done_d) begin
      err_d    = 1'b1;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on the lines.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 300;

  logic       CLOCK_50 = 1'b0;
  logic       reset, send;
  logic [7:0] cmd_byte;
  logic       dev_clk, dev_dat;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe, busy, done, error;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  // Wired-AND open-drain lines: device and host can each pull low.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_host_tx #(.CLK_HZ(50_000_000), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .send       (send),
    .cmd_byte   (cmd_byte),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse bookkeeping: count done/error pulses, check exclusivity and width.
  logic done_p = 1'b0, err_p = 1'b0;
  always @(negedge CLOCK_50) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done || error) begin
      chk("pulse_exclusive", {31'd0, done & error}, 32'd0);
      chk("pulse_width", {31'd0, (done & done_p) | (error & err_p)}, 32'd0);
    end
    done_p = done;
    err_p  = error;
  end

  // One transaction: issue send, play the device side for 11 clocks.
  // abort_edge != 0 pulses reset right after that device falling edge.
  task automatic frame(input string tag, input logic [7:0] cmd, input bit ack, input bit dbl,
                       input int abort_edge, input logic [9:0] exp_bits);
    int d0, e0, n;
    logic [9:0] got;
    d0 = done_cnt;
    e0 = err_cnt;
    got = '0;
    @(negedge CLOCK_50);
    send = 1'b1;
    cmd_byte = cmd;
    @(negedge CLOCK_50);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_inhibit_clk"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd2);
    if (dbl) cmd_byte = 8'h00; else send = 1'b0;
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < 1000) begin
      n++;
      @(negedge CLOCK_50);
      send = 1'b0;
    end
    chk({tag, "_clk_hold"}, n, INH + 16);
    chk({tag, "_start_bit"}, {31'd0, ps2_dat_in}, 32'd0);
    for (int e = 1; e <= 11; e++) begin
      repeat (8) @(negedge CLOCK_50);
      if (e == 11 && ack) dev_dat = 1'b0;
      repeat (4) @(negedge CLOCK_50);
      dev_clk = 1'b0;
      repeat (8) @(negedge CLOCK_50);
      if (e <= 10) got[e-1] = ps2_dat_in;
      dev_clk = 1'b1;
      if (e == abort_edge) begin
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        chk({tag, "_abort_oe"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        chk({tag, "_abort_busy"}, {31'd0, busy}, 32'd0);
        repeat (20) @(negedge CLOCK_50);
        chk({tag, "_abort_done"}, done_cnt - d0, 32'd0);
        chk({tag, "_abort_err"}, err_cnt - e0, 32'd0);
        return;
      end
    end
    repeat (4) @(negedge CLOCK_50);
    dev_dat = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    chk({tag, "_bits"}, {22'd0, got}, {22'd0, exp_bits});
    chk({tag, "_done"}, done_cnt - d0, ack ? 32'd1 : 32'd0);
    chk({tag, "_err"}, err_cnt - e0, ack ? 32'd0 : 32'd1);
    chk({tag, "_idle"}, {29'd0, busy, ps2_clk_oe, ps2_dat_oe}, 32'd0);
  endtask

  initial begin
    int n, d0, e0;
    reset = 1'b1; send = 1'b0; cmd_byte = 8'h00; dev_clk = 1'b1; dev_dat = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk("reset_outs", {27'd0, ps2_clk_oe, ps2_dat_oe, busy, done, error}, 32'd0);
    send = 1'b1; cmd_byte = 8'hAA;
    @(negedge CLOCK_50);
    chk("reset_beats_send", {31'd0, busy}, 32'd0);
    send = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);

    // 0xED: data 1,0,1,1,0,1,1,1 LSB first, parity 1, stop 1
    frame("ed", 8'hED, 1'b1, 1'b0, 0, 10'h3ED);
    // 0xF4: five ones -> parity 0; 0x00 -> parity 1
    frame("f4", 8'hF4, 1'b1, 1'b0, 0, 10'h2F4);
    frame("z0", 8'h00, 1'b1, 1'b0, 0, 10'h300);
    // 0x55: device never ACKs -> error pulse, no done
    frame("noack", 8'h55, 1'b0, 1'b0, 0, 10'h355);
    // Reset after edge 5, then a clean frame
    frame("abort", 8'hED, 1'b1, 1'b0, 5, 10'h000);
    frame("after", 8'hF4, 1'b1, 1'b0, 0, 10'h2F4);
    // Second send a cycle after acceptance is ignored
    frame("dbl", 8'hED, 1'b1, 1'b1, 0, 10'h3ED);

    // 0xFF with silent device: error TMO cycles after REQ exit
    d0 = done_cnt; e0 = err_cnt;
    @(negedge CLOCK_50);
    send = 1'b1; cmd_byte = 8'hFF;
    @(negedge CLOCK_50);
    send = 1'b0;
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < 1000) begin n++; @(negedge CLOCK_50); end
    chk("tmo_req_exit", n, INH + 16);
    n = 0;
    while (error !== 1'b1 && n < TMO + 100) begin n++; @(negedge CLOCK_50); end
    chk("tmo_latency", n, TMO);
    chk("tmo_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge CLOCK_50);
    chk("tmo_err_cnt", err_cnt - e0, 32'd1);
    chk("tmo_no_done", done_cnt - d0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter: CLK_HZ, 50_000_000, system clock frequency.
REQ-002 Parameter: INHIBIT_CYCLES, 6000, clock-low inhibit length (120 us at 50 MHz).
REQ-003 Parameter: TIMEOUT_CYCLES, 1_000_000, max CLOCK_50 cycles between device clock falling edges (20 ms).
REQ-004 Port: CLOCK_50  input  1  system clock; all logic rising-edge on it.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: send  input  1  one-cycle request to transmit cmd_byte.
REQ-007 Port: cmd_byte  input  8  command byte to the keyboard (e.g. 0xED, 0xFF).
REQ-008 Port: ps2_clk_in  input  1  raw PS2_CLK line level.
REQ-009 Port: ps2_dat_in  input  1  raw PS2_DAT line level.
REQ-010 Port: ps2_clk_oe  output  1  1 = pull PS2_CLK low; 0 = release (high-Z).
REQ-011 Port: ps2_dat_oe  output  1  1 = pull PS2_DAT low; 0 = release (high-Z).
REQ-012 Port: busy  output  1  high from accepted send until return to IDLE.
REQ-013 Port: done  output  1  one-cycle pulse: byte sent and device ACK seen.
REQ-014 Port: error  output  1  one-cycle pulse: timeout or missing ACK.

Function
REQ-015 ps2_clk_in and ps2_dat_in SHALL pass a 2-flop synchronizer; a falling edge is synchronized clock 1 then 0 on consecutive cycles.
REQ-016 States SHALL be IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, WAIT_IDLE.
REQ-017 IDLE: send=1 latches cmd_byte and computes odd parity (parity = ~^cmd_byte); next cycle state=INHIBIT, busy=1, ps2_clk_oe=1.
REQ-018 send while busy=1 SHALL be ignored; cmd_byte is only sampled on acceptance.
REQ-019 INHIBIT: hold ps2_clk_oe=1 for INHIBIT_CYCLES cycles, then ps2_dat_oe=1 (start bit) and enter REQ.
REQ-020 REQ: after 16 cycles with both oe=1, release ps2_clk_oe and enter DATA, bit index 0.
REQ-021 Falling edges 1-8 in DATA: ps2_dat_oe = ~cmd_byte[i], i=0..7 LSB first; after edge 8 enter PARITY.
REQ-022 Falling edge 9: ps2_dat_oe = ~parity; enter STOP.
REQ-023 Falling edge 10: ps2_dat_oe=0 (stop bit = 1); enter ACK.
REQ-024 Falling edge 11: sample synchronized data; 0 = ACK, enter WAIT_IDLE; 1 = error pulse, enter IDLE.
REQ-025 WAIT_IDLE: when synchronized clock and data both 1, pulse done, enter IDLE, busy=0 same cycle as done.
REQ-026 Timeout counter SHALL clear on entry to DATA and on every falling edge; reaching TIMEOUT_CYCLES in DATA/PARITY/STOP/ACK/WAIT_IDLE SHALL pulse error, release both lines, enter IDLE.
REQ-027 done and error SHALL never assert in the same cycle; each is exactly one cycle wide.
REQ-028 Falling edges seen in IDLE, INHIBIT or REQ SHALL be ignored.
REQ-029 Both oe outputs SHALL be registered (glitch-free).

Reset
REQ-030 reset=1 SHALL, on the next edge, force IDLE, ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, error=0, counters and synchronizers to idle (1) values.
REQ-031 reset mid-transfer SHALL abort silently (no done/error pulse); reset wins over simultaneous send.

Structure
REQ-032 Package ps2_pkg SHALL hold the state encoding, frame length (11 edges) and default timing constants shared with the PS2 receiver.
REQ-033 One sub-module ps2_sync_edge (2-flop synchronizer plus falling-edge detect) SHALL be used for the clock line; data line uses synchronizer only.
REQ-034 Top-level SHALL realise open-drain as PS2_CLK = ps2_clk_oe ? 0 : Z, likewise PS2_DAT.

Verification
REQ-035 send cmd_byte=0xED, device model clocks 11 edges, ACK low -> data seen 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulse, busy low.
REQ-036 send 0xF4 -> parity bit 0; send 0x00 -> parity bit 1; both done.
REQ-037 send 0xFF, device never clocks -> error pulse at TIMEOUT_CYCLES after REQ exit, both oe=0, no done.
REQ-038 send 0x55, device leaves data high on edge 11 -> error pulse, IDLE, no done.
REQ-039 reset asserted after edge 5 of 0xED -> next cycle both oe=0, busy=0, no pulses; new send 0xF4 completes normally.
REQ-040 second send one cycle after acceptance of 0xED -> ignored; exactly one frame, one done pulse.
